control_unit_pipe: RTL and testbench
====================================

Name: control_unit_pipe

Overview:
- Main decoder for the 3-bit-opcode pipelined MIPS datapath.
- Maps the instruction opcode to the datapath control signals and presents them as registered outputs, i.e. the ID/EX control field.
- Supports pipeline stall (hold) and flush (bubble insertion).
- Sits between the instruction-decode stage and the ID/EX pipeline register consumers: ALU control, data memory, write-back mux and branch logic.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- opCode  input  3  instruction opcode from the ID stage
- stall  input  1  1 = hold all outputs at current values
- flush  input  1  1 = load a bubble (all outputs 0) on next edge
- regDst  output  1  1 = write register is rd; 0 = rt
- aluSrc  output  1  1 = ALU operand B is sign-extended immediate
- memtoReg  output  1  1 = write-back data comes from memory
- regWrite  output  1  register file write enable
- memRead  output  1  data memory read enable
- memWrite  output  1  data memory write enable
- branch  output  1  conditional branch (beq) instruction
- aluOp  output  2  00 add, 01 subtract/compare, 10 R-type funct decode, 11 logical-immediate (and)
- illegal  output  1  opcode is unassigned (6 or 7)

Behaviour:
- Decode table, giving regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, aluOp, illegal:
  - 0 R-type: 1,0,0,1,0,0,0,10,0
  - 1 lw: 0,1,1,1,1,0,0,00,0
  - 2 sw: 0,1,0,0,0,1,0,00,0
  - 3 beq: 0,0,0,0,0,0,1,01,0
  - 4 addi: 0,1,0,1,0,0,0,00,0
  - 5 andi: 0,1,0,1,0,0,0,11,0
  - 6, 7 reserved: all control outputs 0 (NOP), illegal=1
- Decoded don't-care fields are fixed at 0, never X.
- All outputs are registered. Latency is 1 clock: an opCode sampled at rising edge N appears on the outputs after edge N.
- Reset (rst_n=0) asynchronously forces every output, including illegal, to 0 immediately, independent of clk. Outputs remain 0 while rst_n is low.
- First decode after reset release occurs at the first rising edge with rst_n=1.
- Priority at a rising edge with rst_n=1: flush > stall > normal load.
  - flush=1: all outputs become 0, including illegal; stall is ignored.
  - stall=1 and flush=0: all outputs hold their previous values; opCode is ignored.
  - Otherwise: outputs load the decode of the current opCode.
- memRead and memWrite are never 1 simultaneously for any input.
- regWrite=1 only for opcodes 0, 1, 4 and 5.
- opCode is treated as unsigned. The bench drives it by incrementing, so 7 wraps to 0; the decoder handles 7 followed by 0 with no special case.
- An X or Z opCode is not a legal input. Behaviour for it is not guaranteed beyond simulation X propagation.
- No combinational path from opCode to the outputs.

Test Plan:
- Reset: hold rst_n=0 with opCode=0 and clk toggling → all outputs 0. Assert rst_n=0 mid-cycle after lw is loaded → outputs drop to 0 immediately, without waiting for a clk edge.
- Sweep: rst_n=1, stall=flush=0, opCode incremented 0..7 and wrapped to 0 once per clock.
  - Each cycle's outputs match the table one clock later, e.g. opCode=1 → memtoReg=1, memRead=1, aluSrc=1, regWrite=1, aluOp=00.
  - opCode=0 after 7 → regDst=1, regWrite=1, aluOp=10.
- Branch and store: opCode=3 → branch=1, aluOp=01, regWrite=0. opCode=2 → memWrite=1, regWrite=0, memRead=0.
- Illegal: opCode=6 and opCode=7 → illegal=1 and all control outputs 0. A following opCode=4 → illegal=0, aluSrc=1, regWrite=1.
- Stall: load lw, then stall=1 with opCode=2 for 3 cycles → outputs remain at the lw values. Release stall → sw values appear after the next edge.
- Flush priority: opCode=0 with flush=1 and stall=1 on the same edge → all outputs 0 after that edge. Clear flush and stall → R-type values appear one clock later.

Source files
------------

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: main decoder producing the registered ID/EX control field with stall and flush
module control_unit_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opCode,
    input  logic       stall,
    input  logic       flush,
    output logic       regDst,
    output logic       aluSrc,
    output logic       memtoReg,
    output logic       regWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       branch,
    output logic [1:0] aluOp,
    output logic       illegal
);
    // control word: {regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, aluOp, illegal}
    logic [9:0] dec;
    logic [9:0] ctrl_d;
    logic [9:0] ctrl_q;

    // opcode decode; reserved opcodes give a NOP with illegal raised
    always_comb begin
        dec = '0;
        case (opCode)
            3'd0:    dec = 10'b1001000_10_0;
            3'd1:    dec = 10'b0111100_00_0;
            3'd2:    dec = 10'b0100010_00_0;
            3'd3:    dec = 10'b0000001_01_0;
            3'd4:    dec = 10'b0101000_00_0;
            3'd5:    dec = 10'b0101000_11_0;
            default: dec = 10'b0000000_00_1;
        endcase
    end

    // next field: a flush bubble beats a stall hold, which beats a normal load
    always_comb begin
        ctrl_d = flush ? '0 : (stall ? ctrl_q : dec);
    end

    // ID/EX control register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ctrl_q <= '0;
        else
            ctrl_q <= ctrl_d;
    end

    assign {regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, aluOp, illegal} = ctrl_q;
endmodule

// File: tb/tb_control_unit_pipe.sv
// tb_control_unit_pipe: randomized and directed checks of control_unit_pipe against a rule-based model
module tb_control_unit_pipe;
    logic       clk;
    logic       rst_n;
    logic [2:0] opCode;
    logic       stall;
    logic       flush;
    logic       regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, illegal;
    logic [1:0] aluOp;
    logic [9:0] got;
    logic [9:0] exp_q;
    int         total;
    int         bad;

    control_unit_pipe dut (
        .clk(clk), .rst_n(rst_n), .opCode(opCode), .stall(stall), .flush(flush),
        .regDst(regDst), .aluSrc(aluSrc), .memtoReg(memtoReg), .regWrite(regWrite),
        .memRead(memRead), .memWrite(memWrite), .branch(branch), .aluOp(aluOp),
        .illegal(illegal)
    );

    assign got = {regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, aluOp, illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // instruction-class rules turned into the packed control word
    function automatic logic [9:0] model(input logic [2:0] op);
        logic rtype, lw, sw, beq, addi, andi, ill;
        logic [1:0] alu;
        rtype = (op == 3'd0);
        lw    = (op == 3'd1);
        sw    = (op == 3'd2);
        beq   = (op == 3'd3);
        addi  = (op == 3'd4);
        andi  = (op == 3'd5);
        ill   = (op > 3'd5);
        alu   = rtype ? 2'd2 : beq ? 2'd1 : andi ? 2'd3 : 2'd0;
        return {rtype, lw | sw | addi | andi, lw, rtype | lw | addi | andi,
                lw, sw, beq, alu, ill};
    endfunction

    // expected register contents, updated with the same edge semantics as the pipeline stage
    initial exp_q = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exp_q <= '0;
        else if (flush)
            exp_q <= '0;
        else if (!stall)
            exp_q <= model(opCode);
    end

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        total++;
        if (got !== exp_q) begin
            bad++;
            $display("FAIL model t=%0t got=%b want=%b", $time, got, exp_q);
        end
        if (memRead && memWrite) begin
            bad++;
            $display("FAIL rd_wr_excl t=%0t got=%b", $time, got);
        end
    end

    task automatic chk(input string name, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic step(input logic [2:0] op, input logic st, input logic fl);
        opCode = op;
        stall  = st;
        flush  = fl;
        @(negedge clk);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        opCode = 3'd0;
        stall  = 1'b0;
        flush  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hold", 10'b0);
        rst_n = 1'b1;
        // sweep with wrap from 7 back to 0
        opCode = 3'd0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 1) chk("sweep_lw", 10'b0111100000);
            if (i == 2) chk("sweep_sw", 10'b0100010000);
            if (i == 3) chk("sweep_beq", 10'b0000001010);
            if (i == 5) chk("sweep_andi", 10'b0101000110);
            if (i == 8) chk("sweep_wrap_r", 10'b1001000100);
            opCode = opCode + 3'd1;
        end
        // illegal opcodes then addi
        step(3'd6, 1'b0, 1'b0);
        chk("ill6", 10'b0000000001);
        step(3'd7, 1'b0, 1'b0);
        chk("ill7", 10'b0000000001);
        step(3'd4, 1'b0, 1'b0);
        chk("addi_after_ill", 10'b0101000000);
        // stall holds lw while sw is presented
        step(3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(3'd2, 1'b1, 1'b0);
            chk("stall_hold", 10'b0111100000);
        end
        step(3'd2, 1'b0, 1'b0);
        chk("stall_release", 10'b0100010000);
        // flush beats stall
        step(3'd0, 1'b1, 1'b1);
        chk("flush_prio", 10'b0);
        step(3'd0, 1'b0, 1'b0);
        chk("after_flush_r", 10'b1001000100);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        // asynchronous reset mid-cycle after lw
        step(3'd1, 1'b0, 1'b0);
        chk("pre_async_lw", 10'b0111100000);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 10'b0);
        @(negedge clk);
        chk("reset_low_hold", 10'b0);
        rst_n = 1'b1;
        step(3'd3, 1'b0, 1'b0);
        chk("first_after_reset", 10'b0000001010);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
